// File: rtl/xevious_inputs_pkg.sv
// Shared constants and types for the Xevious player-input front end:
// PS/2 scancodes, joystick bit positions, coin FSM states and the button bundle.
package xevious_inputs_pkg;

  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_SPACE = 8'h29;
  localparam logic [7:0] KEY_CTRL  = 8'h14;
  localparam logic [7:0] KEY_F1    = 8'h05;
  localparam logic [7:0] KEY_F2    = 8'h06;

  localparam int JB_R      = 0;
  localparam int JB_L      = 1;
  localparam int JB_D      = 2;
  localparam int JB_U      = 3;
  localparam int JB_FIRE   = 4;
  localparam int JB_BOMB   = 5;
  localparam int JB_START1 = 6;
  localparam int JB_START2 = 7;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GAP
  } coin_state_t;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
    logic fire;
    logic bomb;
    logic start1;
    logic start2;
  } btn_t;

endpackage

// File: rtl/xevious_coin_pulser.sv
// Coin pulse generator: fixed-length high pulse, enforced low gap, and a
// single-entry pending slot for a start press that arrives while busy.
module xevious_coin_pulser
  import xevious_inputs_pkg::*;
#(
  parameter int COIN_PULSE = 1_800_000,
  parameter int COIN_GAP   = 1_800_000,
  parameter int CNT_W      = 21
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic trig,
  output logic coin
);

  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(COIN_PULSE - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(COIN_GAP - 1);

  coin_state_t      state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             pend, pend_nx;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      pend  <= 1'b0;
      coin  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      pend  <= pend_nx;
      coin  <= (state_nx == PULSE);
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    pend_nx  = pend;
    case (state)
      IDLE: begin
        if (trig || pend) begin
          state_nx = PULSE;
          cnt_nx   = PULSE_LD;
          pend_nx  = 1'b0;
        end
      end
      PULSE: begin
        if (trig) pend_nx = 1'b1;
        if (cnt == '0) begin
          state_nx = GAP;
          cnt_nx   = GAP_LD;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      GAP: begin
        // A press that lands here waits in pend; any further press is dropped.
        if (trig) pend_nx = 1'b1;
        if (cnt == '0) state_nx = IDLE;
        else           cnt_nx   = cnt - CNT_W'(1);
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: rtl/xevious_inputs.sv
// Player-input front end: PS/2 key decode, joystick merge, Vert/Horz remap
// and coin pulse generation from start presses. All outputs are registered.
module xevious_inputs
  import xevious_inputs_pkg::*;
#(
  parameter int COIN_PULSE = 1_800_000,
  parameter int COIN_GAP   = 1_800_000,
  parameter int CNT_W      = 21
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joy,
  input  logic        rotate,
  output logic        up,
  output logic        down,
  output logic        left,
  output logic        right,
  output logic        fire,
  output logic        bomb,
  output logic        start1,
  output logic        start2,
  output logic        coin
);

  logic prev_tgl, primed, key_evt;
  btn_t lat, k, out_q;
  logic start_q, trig_q, k_start;
  logic joy_hi_unused;

  assign joy_hi_unused = ^joy[15:8];

  // The first edge after reset only captures the toggle level, so a strobe
  // held high through reset never looks like a fresh key event.
  assign key_evt = primed && (ps2_key[10] != prev_tgl);

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      prev_tgl <= 1'b0;
      primed   <= 1'b0;
    end else begin
      prev_tgl <= ps2_key[10];
      primed   <= 1'b1;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      lat <= '0;
    end else if (key_evt) begin
      case (ps2_key[7:0])
        KEY_UP:    lat.up    <= ps2_key[9];
        KEY_DOWN:  lat.down  <= ps2_key[9];
        KEY_LEFT:  lat.left  <= ps2_key[9];
        KEY_RIGHT: lat.right <= ps2_key[9];
        KEY_CTRL:  lat.bomb  <= ps2_key[9];
        KEY_SPACE: if (!ps2_key[8]) lat.fire   <= ps2_key[9];
        KEY_F1:    if (!ps2_key[8]) lat.start1 <= ps2_key[9];
        KEY_F2:    if (!ps2_key[8]) lat.start2 <= ps2_key[9];
        default: ;
      endcase
    end
  end

  always_comb begin
    k        = lat;
    k.up     = lat.up     | joy[JB_U];
    k.down   = lat.down   | joy[JB_D];
    k.left   = lat.left   | joy[JB_L];
    k.right  = lat.right  | joy[JB_R];
    k.fire   = lat.fire   | joy[JB_FIRE];
    k.bomb   = lat.bomb   | joy[JB_BOMB];
    k.start1 = lat.start1 | joy[JB_START1];
    k.start2 = lat.start2 | joy[JB_START2];
  end

  assign k_start = k.start1 | k.start2;

  // Horz cabinet: the stick is turned a quarter so directions rotate.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      out_q   <= '0;
      start_q <= 1'b0;
      trig_q  <= 1'b0;
    end else begin
      out_q.up     <= rotate ? k.left  : k.up;
      out_q.down   <= rotate ? k.right : k.down;
      out_q.left   <= rotate ? k.down  : k.left;
      out_q.right  <= rotate ? k.up    : k.right;
      out_q.fire   <= k.fire;
      out_q.bomb   <= k.bomb;
      out_q.start1 <= k.start1;
      out_q.start2 <= k.start2;
      start_q      <= k_start;
      trig_q       <= k_start & ~start_q;
    end
  end

  xevious_coin_pulser #(
    .COIN_PULSE(COIN_PULSE),
    .COIN_GAP  (COIN_GAP),
    .CNT_W     (CNT_W)
  ) u_coin (
    .clk_sys(clk_sys),
    .reset  (reset),
    .trig   (trig_q),
    .coin   (coin)
  );

  assign up     = out_q.up;
  assign down   = out_q.down;
  assign left   = out_q.left;
  assign right  = out_q.right;
  assign fire   = out_q.fire;
  assign bomb   = out_q.bomb;
  assign start1 = out_q.start1;
  assign start2 = out_q.start2;

endmodule

// File: tb/tb_xevious_inputs.sv
// Bench for xevious_inputs: table of key/joystick/rotate vectors with
// hand-computed outputs, plus hand-written coin pulse and reset sequences.
module tb_xevious_inputs;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic [10:0] ps2_key = '0;
  logic [15:0] joy     = '0;
  logic        rotate  = 1'b0;
  logic up, down, left, right, fire, bomb, start1, start2, coin;
  logic [8:0] got;

  int total = 0;
  int bad   = 0;
  logic tgl = 1'b0;

  // Output word order: up down left right fire bomb start1 start2 coin
  assign got = {up, down, left, right, fire, bomb, start1, start2, coin};

  always #5 clk_sys = ~clk_sys;

  xevious_inputs #(
    .COIN_PULSE(4),
    .COIN_GAP  (3),
    .CNT_W     (3)
  ) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .ps2_key(ps2_key),
    .joy    (joy),
    .rotate (rotate),
    .up     (up),
    .down   (down),
    .left   (left),
    .right  (right),
    .fire   (fire),
    .bomb   (bomb),
    .start1 (start1),
    .start2 (start2),
    .coin   (coin)
  );

  typedef struct {
    logic        evt;
    logic        pressed;
    logic        ext;
    logic [7:0]  code;
    logic [15:0] joy;
    logic        rot;
    int          edges;
    logic [8:0]  exp;
  } vec_t;

  vec_t vecs[24];

  logic [15:0] seq_joy[23];
  logic        seq_coin[23];

  task automatic step();
    @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  initial begin
    // evt pr ext code joy rot edges exp
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 8'h75, 16'h0000, 1'b0, 1, 9'h000};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 8'h75, 16'h0000, 1'b0, 1, 9'h100};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 8'h75, 16'h0000, 1'b0, 2, 9'h000};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 8'h29, 16'h0000, 1'b0, 2, 9'h000};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'h29, 16'h0000, 1'b0, 2, 9'h010};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 8'h29, 16'h0000, 1'b0, 2, 9'h000};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 8'h14, 16'h0000, 1'b0, 2, 9'h008};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'h14, 16'h0000, 1'b0, 2, 9'h000};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'h14, 16'h0008, 1'b1, 1, 9'h020};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'h14, 16'h0002, 1'b1, 1, 9'h100};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h14, 16'h0001, 1'b1, 1, 9'h080};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 8'h14, 16'h0004, 1'b1, 1, 9'h040};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 8'h14, 16'h0004, 1'b0, 1, 9'h080};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 8'h14, 16'h0030, 1'b0, 1, 9'h018};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 8'h14, 16'h0000, 1'b0, 1, 9'h000};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 8'h6B, 16'h0020, 1'b0, 1, 9'h008};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 8'h6B, 16'h0020, 1'b0, 1, 9'h048};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 8'h6B, 16'h0020, 1'b1, 1, 9'h108};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 8'h6B, 16'h0000, 1'b0, 2, 9'h000};
    vecs[19] = '{1'b1, 1'b1, 1'b1, 8'h74, 16'h0000, 1'b0, 2, 9'h020};
    vecs[20] = '{1'b1, 1'b1, 1'b0, 8'h1C, 16'h0000, 1'b0, 2, 9'h020};
    vecs[21] = '{1'b1, 1'b0, 1'b0, 8'h74, 16'h0000, 1'b0, 2, 9'h000};
    vecs[22] = '{1'b0, 1'b0, 1'b0, 8'h74, 16'h0100, 1'b0, 1, 9'h000};
    vecs[23] = '{1'b1, 1'b1, 1'b1, 8'h05, 16'h0000, 1'b0, 3, 9'h000};

    // Start presses: first rise, second rise in PULSE, third in GAP
    for (int i = 0; i < 23; i++) begin
      seq_joy[i]  = (i == 1 || i == 4) ? 16'h0000 : 16'h0040;
      seq_coin[i] = ((i >= 1 && i <= 4) || (i >= 9 && i <= 12)) ? 1'b1 : 1'b0;
    end

    // Reset with the strobe high and an up-press on the bus
    tgl     = 1'b1;
    ps2_key = {tgl, 1'b1, 1'b0, 8'h75};
    repeat (3) step();
    check("in_reset", got, 9'h000);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("primed_idle_%0d", i), got, 9'h000);
    end

    for (int i = 0; i < 24; i++) begin
      if (vecs[i].evt) tgl = ~tgl;
      ps2_key = {tgl, vecs[i].pressed, vecs[i].ext, vecs[i].code};
      joy     = vecs[i].joy;
      rotate  = vecs[i].rot;
      repeat (vecs[i].edges) step();
      check($sformatf("vec_%0d", i), got, vecs[i].exp);
    end

    // Single coin pulse with start1 held
    joy = 16'h0040;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("coin1_%0d", i), got,
            {6'b0, 1'b1, 1'b0, (i >= 1 && i <= 4) ? 1'b1 : 1'b0});
    end
    joy = 16'h0000;
    repeat (3) step();
    check("coin1_settle", got, 9'h000);

    // Queued restart after the gap; extra trigger dropped
    for (int i = 0; i < 23; i++) begin
      joy = seq_joy[i];
      step();
      check($sformatf("coin_q_%0d", i), {8'b0, coin}, {8'b0, seq_coin[i]});
    end

    // Reset mid-pulse
    joy = 16'h0000;
    repeat (3) step();
    joy = 16'h0040;
    repeat (3) step();
    check("pre_reset_coin", {8'b0, coin}, 9'h001);
    joy     = 16'h0000;
    tgl     = 1'b1;
    ps2_key = {tgl, 1'b1, 1'b0, 8'h75};
    #1 reset = 1'b1;
    #1 check("async_reset", got, 9'h000);
    step();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      check($sformatf("post_reset_%0d", i), got, 9'h000);
    end
    joy = 16'h0040;
    step();
    check("restart_1", got, 9'h004);
    step();
    check("restart_2", got, 9'h005);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
